fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the PC's current address and issues requests to instruction memory over a valid/ready handshake.
- Buffers in-order responses in a small FIFO and presents {instruction, pc, pc+4} to decode over valid/ready.
- Back-pressures the PC via pc_stall and discards all in-flight and buffered work on flush (taken branch, jump or jr).

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of buffered plus outstanding requests (power of two, at least 2).
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_addr  input  ADDR_W  current PC address.
- pc_stall  output  1  high means the PC must hold its value this cycle.
- flush  input  1  redirect; kills the queue and all in-flight requests.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_W  fetch address; equals pc_addr combinationally.
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  instruction returned; responses arrive in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  DATA_W  returned instruction.
- if_valid  output  1  head entry valid toward decode.
- if_instr  output  DATA_W  head instruction.
- if_pc  output  ADDR_W  head instruction address.
- if_pc_plus4  output  ADDR_W  if_pc + 4, modulo 2^ADDR_W.
- id_ready  input  1  decode accepts the head.

Behaviour:
- Async reset (reset=0):
  - Clear occupancy, outstanding count, drop count, and read/write pointers.
  - if_valid=0, imem_req_valid=0, pc_stall=1; if_instr, if_pc and if_pc_plus4 read 0.
  - Reset asserted mid-operation abandons everything; responses arriving during reset are ignored.
- Credit: credit_ok = (occupancy + outstanding) < DEPTH. Counters are clog2(DEPTH)+1 bits wide and never wrap.
- Request:
  - imem_req_valid = reset && credit_ok && !flush && (drop_count==0).
  - req_fire = imem_req_valid && imem_req_ready.
  - On fire, push pc_addr into an address-tag FIFO (DEPTH deep) and increment outstanding.
- pc_stall = !req_fire. The PC advances only on a cycle where a request is accepted.
- Response:
  - If drop_count>0, decrement drop_count and discard the data.
  - Otherwise write {data, tag-FIFO head address} into the queue, pop the tag, decrement outstanding and increment occupancy.
  - Credit guarantees the queue is never full on a response. An overflow is a bench assertion failure.
- Decode side:
  - if_valid = (occupancy>0) && !flush.
  - pop = if_valid && id_ready, which advances the read pointer.
  - Outputs are registered queue contents; minimum latency from rsp to if_valid is 1 cycle.
- Simultaneous push and pop: occupancy unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- Simultaneous request fire and response: outstanding unchanged.
- Flush (same-cycle effect, takes priority over every other event):
  - Occupancy and pointers are cleared and the tag FIFO is emptied.
  - if_valid is forced low and no pop occurs.
  - No request is issued; pc_stall=1, so the PC loads the redirect target that cycle.
  - drop_count <= outstanding − (rsp_valid && drop_count==0 ? 1 : 0) + drop_count − (rsp_valid && drop_count>0 ? 1 : 0). Every response already owed is discarded, including one arriving in the flush cycle.
- Back-to-back flush: each flush recomputes drop_count by the same rule and does not double-count.
- New requests resume only once drop_count==0. This guarantees the first post-flush response belongs to the redirect target.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - Occupancy==0, drop_count==0, rsp_valid=1 and !flush: if_valid is driven combinationally from the response, with if_instr=imem_rsp_data and if_pc=tag head.
  - If id_ready is also 1, the entry is consumed with no queue write (0-cycle latency).
  - If id_ready=0, the entry is written normally.
- Undefined: no combinational path from imem_rsp_* to if_*; latency is exactly 1 cycle minimum.

Test Plan:
- Reset held low 3 cycles with rsp_valid=1 -> if_valid=0, imem_req_valid=0, pc_stall=1. First cycle after release with ready=1 -> request addr 0x0, pc_stall=0.
- Streaming, 1-cycle memory latency, id_ready=1, PC stepping 0,4,8,12 -> decode sees if_pc 0,4,8,12 with matching instrs, if_pc_plus4 4,8,12,16, no gaps after the first.
- id_ready=0, DEPTH=4 -> exactly 4 requests accepted, then pc_stall=1, imem_req_valid=0. Raise id_ready -> one request resumes per pop.
- 2 requests outstanding, flush asserted while one rsp arrives -> that rsp and the next are dropped; a request for the new PC=0x40 is issued only after drop_count==0; first if_pc=0x40.
- Simultaneous push, pop and req_fire at occupancy 2 -> occupancy stays 2, outstanding unchanged, order preserved. Pointer wrap exercised over 10 entries.
- FETCH_BYPASS_EN defined, empty queue, rsp at cycle N with id_ready=1 -> if_valid=1 in cycle N. Macro undefined -> if_valid=1 in cycle N+1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues imem requests behind the PC and buffers responses for decode.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  input  logic              id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [CW-1:0] occ, outst, drop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] tag_rd, tag_wr;

  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [ADDR_W-1:0] tag_mem [DEPTH];

  logic [CW:0]   load;
  logic          credit_ok, drop_idle, req_fire;
  logic          rsp_acc, rsp_drop, q_has;
  logic          byp, byp_take, q_pop, q_push;
  logic [CW-1:0] drop_flush;

  assign load      = {1'b0, occ} + {1'b0, outst};
  assign credit_ok = load < CAP;
  assign drop_idle = (drop == '0);

  assign imem_req_valid = reset & credit_ok & ~flush & drop_idle;
  assign imem_req_addr  = pc_addr;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign pc_stall       = ~req_fire;

  assign rsp_acc  = imem_rsp_valid & drop_idle & ~flush;
  assign rsp_drop = imem_rsp_valid & ~drop_idle;
  assign q_has    = (occ != '0);

`ifdef FETCH_BYPASS_EN
  assign byp = reset & ~q_has & rsp_acc;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp & id_ready;
  assign q_pop    = q_has & ~flush & id_ready;
  assign q_push   = rsp_acc & ~byp_take;

  // every response still owed, including one landing this cycle, is discarded
  assign drop_flush = outst + drop - CW'(imem_rsp_valid);

  always_comb begin
    if_valid = q_has & ~flush;
    if_instr = q_instr[rd_ptr];
    if_pc    = q_pc[rd_ptr];
    if (byp) begin
      if_valid = 1'b1;
      if_instr = imem_rsp_data;
      if_pc    = tag_mem[tag_rd];
    end
  end

  assign if_pc_plus4 = reset ? if_pc + ADDR_W'(4) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ    <= '0;
      outst  <= '0;
      drop   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
    end else if (flush) begin
      occ    <= '0;
      outst  <= '0;
      drop   <= drop_flush;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      occ   <= occ + CW'(q_push) - CW'(q_pop);
      outst <= outst + CW'(req_fire) - CW'(rsp_acc);
      drop  <= drop - CW'(rsp_drop);
      if (q_push)   wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)    rd_ptr <= rd_ptr + 1'b1;
      if (req_fire) tag_wr <= tag_wr + 1'b1;
      if (rsp_acc)  tag_rd <= tag_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      if (q_push) begin
        q_instr[wr_ptr] <= imem_rsp_data;
        q_pc[wr_ptr]    <= tag_mem[tag_rd];
      end
      if (req_fire) tag_mem[tag_wr] <= pc_addr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC model, 1-cycle memory model, scripted flush responses.
// Follows FETCH_BYPASS_EN to pick the expected response-to-decode latency.
`timescale 1ns/1ps
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        pc_stall;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;

  logic        mem_auto;
  logic        man_v;
  logic [31:0] man_d;
  logic        auto_v;
  logic [31:0] auto_d;
  logic [31:0] redirect;
  logic        ovf = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .pc_addr(pc_addr),
    .pc_stall(pc_stall),
    .flush(flush),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4),
    .id_ready(id_ready)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) pc_addr <= 32'h0;
    else if (flush) pc_addr <= redirect;
    else if (!pc_stall) pc_addr <= pc_addr + 32'd4;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_v <= 1'b0;
      auto_d <= 32'h0;
    end else begin
      auto_v <= imem_req_valid && imem_req_ready;
      auto_d <= 32'h1300_0000 | imem_req_addr;
    end
  end

  assign imem_rsp_valid = mem_auto ? auto_v : man_v;
  assign imem_rsp_data  = mem_auto ? auto_d : man_d;

  always @(negedge clk) if (dut.occ > 3'd4) ovf <= 1'b1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    mem_auto = 1'b0;
    man_v = 1'b1;
    man_d = 32'hDEAD_BEEF;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_if_valid got %b want 0", if_valid);
    end
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (pc_stall !== 1'b1) begin
      errors++; $display("FAIL reset_pc_stall got %b want 1", pc_stall);
    end
    checks++;
    if ({if_instr, if_pc, if_pc_plus4} !== 96'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h want 0", if_instr, if_pc, if_pc_plus4);
    end
    reset = 1'b1;
    man_v = 1'b0;
    mem_auto = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL release_req got v=%b a=%h st=%b want 1 0 0",
               imem_req_valid, imem_req_addr, pc_stall);
    end
  endtask

  task automatic test_stream();
    for (int c = 1; c <= 6; c++) begin
      int k;
      step();
      k = c - LAT;
      checks++;
      if (k < 0) begin
        if (if_valid !== 1'b0) begin
          errors++; $display("FAIL stream_c%0d_valid got %b want 0", c, if_valid);
        end
      end else if (if_valid !== 1'b1 || if_pc !== 32'(4*k) ||
                   if_instr !== (32'h1300_0000 | 32'(4*k)) ||
                   if_pc_plus4 !== 32'(4*k+4)) begin
        errors++;
        $display("FAIL stream_c%0d got v=%b pc=%h ins=%h p4=%h want pc=%h",
                 c, if_valid, if_pc, if_instr, if_pc_plus4, 32'(4*k));
      end
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    mem_auto = 1'b1;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) step();
      if (imem_req_valid && imem_req_ready) fires++;
    end
    checks++;
    if (fires !== 4) begin
      errors++; $display("FAIL bp_fires got %0d want 4", fires);
    end
    checks++;
    if (pc_stall !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got st=%b v=%b want 1 0", pc_stall, imem_req_valid);
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h want 1 0", if_valid, if_pc);
    end
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_c6_req got %b want 0", imem_req_valid);
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10 || if_pc !== 32'h4) begin
      errors++;
      $display("FAIL bp_c7 got v=%b a=%h pc=%h want 1 10 4",
               imem_req_valid, imem_req_addr, if_pc);
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14 || if_pc !== 32'h8) begin
      errors++;
      $display("FAIL bp_c8 got v=%b a=%h pc=%h want 1 14 8",
               imem_req_valid, imem_req_addr, if_pc);
    end
  endtask

  task automatic test_flush();
    mem_auto = 1'b0;
    man_v = 1'b0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    redirect = 32'h40;
    do_reset();
    step();
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    man_v = 1'b1;
    man_d = 32'hAAAA_0000;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_c3 got iv=%b rv=%b st=%b want 0 0 1",
               if_valid, imem_req_valid, pc_stall);
    end
    @(negedge clk);
    man_v = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_c4_req got %b want 0", imem_req_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    imem_req_ready = 1'b1;
    man_v = 1'b1;
    man_d = 32'hBBBB_0004;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got rv=%b iv=%b want 0 0", imem_req_valid, if_valid);
    end
    @(negedge clk);
    man_v = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
      errors++;
      $display("FAIL flush_resume got v=%b a=%h want 1 40", imem_req_valid, imem_req_addr);
    end
    @(negedge clk);
    man_v = 1'b1;
    man_d = 32'h1300_0040;
    #1;
    checks++;
`ifdef FETCH_BYPASS_EN
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1300_0040) begin
      errors++;
      $display("FAIL flush_bypass got v=%b pc=%h ins=%h want 1 40 13000040",
               if_valid, if_pc, if_instr);
    end
`else
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL flush_nolat got %b want 0", if_valid);
    end
`endif
    @(negedge clk);
    man_v = 1'b0;
    #1;
    checks++;
`ifdef FETCH_BYPASS_EN
    if (if_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dup got %b want 0", if_valid);
    end
`else
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1300_0040 ||
        if_pc_plus4 !== 32'h44) begin
      errors++;
      $display("FAIL flush_first got v=%b pc=%h ins=%h p4=%h want 1 40 13000040 44",
               if_valid, if_pc, if_instr, if_pc_plus4);
    end
`endif
  endtask

  task automatic test_back_to_back();
    mem_auto = 1'b1;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    id_ready = 1'b1;
    #1;
    checks++;
    if (dut.occ !== 3'd2 || dut.outst !== 3'd1 || !(imem_req_valid && imem_req_ready) ||
        imem_rsp_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL b2b_setup got occ=%0d out=%0d rv=%b rsp=%b pc=%h want 2 1 1 1 0",
               dut.occ, dut.outst, imem_req_valid, imem_rsp_valid, if_pc);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4*k) ||
          if_instr !== (32'h1300_0000 | 32'(4*k)) ||
          dut.occ !== 3'd2 || dut.outst !== 3'd1) begin
        errors++;
        $display("FAIL b2b_k%0d got v=%b pc=%h ins=%h occ=%0d out=%0d want pc=%h occ=2 out=1",
                 k, if_valid, if_pc, if_instr, dut.occ, dut.outst, 32'(4*k));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    id_ready = 1'b0;
    imem_req_ready = 1'b0;
    mem_auto = 1'b0;
    man_v = 1'b0;
    man_d = 32'h0;
    redirect = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL queue_overflow got %b want 0", ovf);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
